ifetch_unit: RTL

Instruction-fetch responder for `pc_logic`. It takes the fetch address `pc` and issues it to instruction memory over a request/grant and in-order response bus. Fetched words are buffered in a small in-order queue and presented to decode as `inst`. It returns `do_update` so `pc_logic` advances only when a fetch is actually accepted. It also consumes `branch_taken` to squash wrong-path fetches.

---
 rtl/arm32_base.sv | 6 +
 rtl/fetch_slot_ring.sv | 75 +++++++
 rtl/ifetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/arm32_base.sv
// Constants shared across the fetch front end.
// Reset PC and architectural word size.
package arm32_base;
   localparam logic [31:0] RESET_PC   = 32'd0;
   localparam int unsigned WORD_BYTES = 4;
endpackage

// File: rtl/fetch_slot_ring.sv
// In-order slot ring: fetch PC, fetched word and filled flag per slot.
// Tracks alloc/fill/head pointers, used and in-flight counts.
module fetch_slot_ring
   import arm32_base::*;
#(
   parameter int QDEPTH = 2,
   localparam int PW = $clog2(QDEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clk,
   input  logic          i_reset,
   input  logic          i_flush,
   input  logic          i_alloc_en,
   input  logic [31:0]   i_alloc_pc,
   input  logic          i_fill_en,
   input  logic [31:0]   i_fill_data,
   input  logic          i_deq_en,
   output logic [CW-1:0] o_used,
   output logic [CW-1:0] o_pend,
   output logic [31:0]   o_inst,
   output logic [31:0]   o_inst_pc,
   output logic          o_inst_valid
);

   localparam logic [PW-1:0] P_ONE = PW'(1);

   logic [31:0]       r_pc   [QDEPTH];
   logic [31:0]       r_word [QDEPTH];
   logic [QDEPTH-1:0] r_filled;
   logic [PW-1:0]     r_alloc;
   logic [PW-1:0]     r_fill;
   logic [PW-1:0]     r_head;
   logic [CW-1:0]     r_used;
   logic [CW-1:0]     r_pend;

   always_ff @(posedge clk) begin
      if (i_reset || i_flush) begin
         r_alloc  <= '0;
         r_fill   <= '0;
         r_head   <= '0;
         r_used   <= '0;
         r_pend   <= '0;
         r_filled <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            r_pc[i]   <= RESET_PC;
            r_word[i] <= '0;
         end
      end else begin
         // Clear on dequeue so a stale flag never shows as a valid head.
         if (i_deq_en) begin
            r_filled[r_head] <= 1'b0;
            r_head           <= r_head + P_ONE;
         end
         if (i_alloc_en) begin
            r_pc[r_alloc]     <= i_alloc_pc;
            r_filled[r_alloc] <= 1'b0;
            r_alloc           <= r_alloc + P_ONE;
         end
         if (i_fill_en) begin
            r_word[r_fill]   <= i_fill_data;
            r_filled[r_fill] <= 1'b1;
            r_fill           <= r_fill + P_ONE;
         end
         r_used <= r_used + CW'(i_alloc_en) - CW'(i_deq_en);
         r_pend <= r_pend + CW'(i_alloc_en) - CW'(i_fill_en);
      end
   end

   assign o_used       = r_used;
   assign o_pend       = r_pend;
   assign o_inst_valid = r_filled[r_head];
   assign o_inst       = r_filled[r_head] ? r_word[r_head] : '0;
   assign o_inst_pc    = r_pc[r_head];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues pc to imem, buffers words in order,
// and squashes wrong-path fetches on a taken branch.
module ifetch_unit
   import arm32_base::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        branch_taken,
   output logic        do_update,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   input  logic        inst_ready
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] C_ONE = CW'(1);

   logic [CW-1:0] w_used;
   logic [CW-1:0] w_pend;
   logic [CW-1:0] r_discard;
   logic [CW:0]   w_credits;
   logic          w_deq;
   logic          w_flush;
   logic          w_grant;
   logic          w_rv_ok;
   logic          w_fill;

   assign w_deq   = inst_valid && inst_ready;
   assign w_flush = w_deq && branch_taken;

   // The slot freed by this cycle's dequeue can be reused at once.
   assign w_credits = (CW+1)'(QDEPTH) + (CW+1)'(w_deq)
                    - {1'b0, w_used} - {1'b0, r_discard};

   assign imem_req  = !reset && (w_credits != '0) && !w_flush;
   assign imem_addr = pc;
   assign w_grant   = imem_req && imem_gnt;
   assign do_update = w_grant || (w_flush && !reset);

   assign w_rv_ok = imem_rvalid && ((r_discard != '0) || (w_pend != '0));
   assign w_fill  = imem_rvalid && (r_discard == '0)
                 && (w_pend != '0) && !w_flush;

   // On flush every in-flight response must be dropped, minus the one
   // consumed this cycle (from discard or from a squashed slot).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_discard <= '0;
      end else if (w_flush) begin
         r_discard <= r_discard + w_pend - CW'(w_rv_ok);
      end else if (imem_rvalid && (r_discard != '0)) begin
         r_discard <= r_discard - C_ONE;
      end
   end

   fetch_slot_ring #(
      .QDEPTH(QDEPTH)
   ) u_ring (
      .clk         (clk),
      .i_reset     (reset),
      .i_flush     (w_flush),
      .i_alloc_en  (w_grant),
      .i_alloc_pc  (pc),
      .i_fill_en   (w_fill),
      .i_fill_data (imem_rdata),
      .i_deq_en    (w_deq),
      .o_used      (w_used),
      .o_pend      (w_pend),
      .o_inst      (inst),
      .o_inst_pc   (inst_pc),
      .o_inst_valid(inst_valid)
   );

endmodule
